// File: rtl/keypad_matrix_responder_if.sv
// Scanner-side bundle for the keypad responder: press request/status plus the
// active-low column drive and row sense lines of the 4x4 matrix.
interface keypad_matrix_responder_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] SW_C;
    logic [3:0] SW_R;
    logic       busy;
    logic       done;

    modport master (
        output key_valid, key_code, SW_C,
        input  SW_R, busy, done
    );

    modport slave (
        input  key_valid, key_code, SW_C,
        output SW_R, busy, done
    );
endinterface

// File: rtl/keypad_matrix_responder.sv
// Passive 4x4 keypad emulation: plays one programmed key press with contact
// bounce, hold and release bounce, answering the scanner's column drive.
module keypad_matrix_responder #(
    parameter int BOUNCE_CYC = 4,
    parameter int HOLD_CYC   = 16,
    parameter int CNT_W      = 8
) (
    input  logic                           clk,
    input  logic                           res,
    keypad_matrix_responder_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PBOUNCE = 2'd1,
        HOLD    = 2'd2,
        RBOUNCE = 2'd3
    } state_t;

    // Terminal counts; a zero bounce length never reaches the bounce states.
    localparam int                 B_LAST_I    = (BOUNCE_CYC > 0) ? (BOUNCE_CYC - 1) : 0;
    localparam int                 H_LAST_I    = (HOLD_CYC > 0) ? (HOLD_CYC - 1) : 0;
    localparam logic [CNT_W-1:0]   BOUNCE_LAST = CNT_W'(B_LAST_I);
    localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(H_LAST_I);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [3:0]         key_r, key_nxt_s;
    logic               contact_r, contact_nxt_s;
    logic               busy_r;
    logic               done_r, done_nxt_s;
    logic [3:0]         sw_r_s;

    // Next-state, counter and key-latch decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        key_nxt_s   = key_r;
        case (state_r)
            IDLE: begin
                if (bus.key_valid) begin
                    key_nxt_s = bus.key_code;
                    cnt_nxt_s = '0;
                    if (BOUNCE_CYC == 0) begin
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = PBOUNCE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PBOUNCE: begin
                if (cnt_r == BOUNCE_LAST) begin
                    state_nxt_s = HOLD;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    cnt_nxt_s = '0;
                    if (BOUNCE_CYC == 0) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RBOUNCE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            RBOUNCE: begin
                if (cnt_r == BOUNCE_LAST) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Contact level for the coming cycle: press chatter closes on even phases,
    // release chatter opens on even phases.
    always_comb begin
        contact_nxt_s = 1'b0;
        case (state_nxt_s)
            IDLE:    contact_nxt_s = 1'b0;
            PBOUNCE: contact_nxt_s = ~cnt_nxt_s[0];
            HOLD:    contact_nxt_s = 1'b1;
            RBOUNCE: contact_nxt_s = cnt_nxt_s[0];
            default: contact_nxt_s = 1'b0;
        endcase
        done_nxt_s = (state_r != IDLE) && (state_nxt_s == IDLE);
    end

    // State and status registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            key_r     <= 4'h0;
            contact_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            key_r     <= key_nxt_s;
            contact_r <= contact_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            done_r    <= done_nxt_s;
        end
    end

    // Row sense follows the column drive without a clock, like a real switch.
    always_comb begin
        sw_r_s = 4'b1111;
        if (contact_r && (bus.SW_C[key_r[1:0]] == 1'b0)) begin
            sw_r_s[key_r[3:2]] = 1'b0;
        end else begin
            sw_r_s = 4'b1111;
        end
    end

    assign bus.SW_R = sw_r_s;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: doc/keypad_matrix_responder.md
Name: keypad_matrix_responder

Overview:
Behavioural-synthesizable model of a 4x4 matrix keypad: the passive end of the row/column scan interface. It receives the active-low column drive (SW_C) from a keypad scanner and returns active-low row sense lines (SW_R). It emulates one programmed key press with contact bounce, hold and bounce-on-release. It is used in benches and on-board loopback to exercise the keypad scanner/decoder without physical keys.

Parameters:
BOUNCE_CYC, 4, number of clk cycles of contact chatter on press and on release (0 = clean edges)
HOLD_CYC, 16, number of clk cycles the contact stays solidly closed between bounce phases (min 1)
CNT_W, 8, width of the internal phase counter; must hold max(BOUNCE_CYC, HOLD_CYC)

Ports:
clk  input  1  system clock, all state changes on rising edge
res  input  1  asynchronous, active-high reset
key_valid  input  1  request to press key_code; sampled only in IDLE
key_code  input  4  key to press: [3:2] = row index, [1:0] = column index
SW_C  input  4  column drive from scanner, active-low (0 = column selected)
SW_R  output  4  row sense to scanner, active-low (0 = pressed key connects row to a selected column)
busy  output  1  high while a press sequence is in progress (state != IDLE)
done  output  1  one-cycle pulse when the sequence ends and the FSM returns to IDLE

Behaviour:
- Reset (async, res=1): state=IDLE, contact=0, counter=0, latched key=0, busy=0, done=0, SW_R=4'b1111 immediately, independent of clk.
- Row output is combinational from SW_C and registered state: SW_R[r]=0 iff contact=1 and r==key_row and SW_C[key_col]==0; else SW_R[r]=1. Other SW_C bits are ignored, with no ghosting. Several low SW_C bits still drive only key_row.
- At most one SW_R bit is ever 0.
- FSM states: IDLE, PBOUNCE, HOLD, RBOUNCE.
- IDLE: contact=0. On a clk edge with key_valid=1, key_code is latched and counter is cleared. The next state is PBOUNCE, or HOLD if BOUNCE_CYC=0. key_valid in any other state is ignored; there is no queueing.
- PBOUNCE: runs for BOUNCE_CYC cycles, k=0..BOUNCE_CYC-1. contact=1 on even k and 0 on odd k. After the last k the FSM goes to HOLD with counter cleared.
- HOLD: runs for HOLD_CYC cycles with contact=1. It then goes to RBOUNCE, or IDLE if BOUNCE_CYC=0.
- RBOUNCE: runs for BOUNCE_CYC cycles. contact=0 on even k and 1 on odd k. After the last k the FSM goes to IDLE.
- done=1 for exactly the first cycle back in IDLE. busy=1 in PBOUNCE, HOLD and RBOUNCE.
- contact, busy and done are registered. Latency: key_valid sampled at edge N puts contact=1 in cycle N+1.
- Total sequence length: 2*BOUNCE_CYC+HOLD_CYC cycles from the first non-IDLE cycle to the first IDLE cycle.
- Back-to-back: key_valid=1 during the done cycle is accepted (IDLE), and a new sequence starts the next cycle.
- res asserted mid-sequence aborts immediately to the reset state. No done pulse is generated.
- Counter never wraps; it compares against parameter minus 1 and clears on each phase change.

Test Plan:
- Reset: res=1 with SW_C=4'b0000 -> SW_R=4'b1111, busy=0, done=0. Release res, no key_valid -> SW_R stays 4'b1111 for 20 cycles.
- Clean press: BOUNCE_CYC=0, HOLD_CYC=16, key_code=4'h6 (row1,col2), SW_C held 4'b1011 -> SW_R=4'b1101 for exactly 16 cycles starting 1 cycle after key_valid, then 4'b1111. done pulses once, 16 cycles after the first busy cycle.
- Column mismatch: same press, but SW_C cycles through 4'b1110, 4'b1101, 4'b0111 only -> SW_R always 4'b1111. With scan 4'b1011 included, SW_R=4'b1101 only in the 4'b1011 cycles.
- Bounce: defaults, key_code=4'hF, SW_C=4'b0111 -> SW_R[3] pattern 0,1,0,1, then sixteen 0s, then 1,0,1,0, then 1. busy=1 for 24 cycles.
- Ignored/back-to-back: key_valid pulsed mid-HOLD -> no effect on the sequence. key_valid=1 in the done cycle with key_code=4'h0 -> new sequence starts next cycle on row0/col0.
- Abort: res pulsed for 1 cycle in HOLD -> SW_R=4'b1111 asynchronously, busy=0, no done. A later key_valid starts a fresh full sequence.
